// File: rtl/stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_arbiter
// Brief    : Round-robin N:1 arbiter for 32-bit stb/ack streams with bounded
//            bursts, one registered word in flight and a sticky stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module stream_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*32-1:0] input_in,
    input  logic [N-1:0]    input_in_stb,
    output logic [N-1:0]    input_in_ack,
    output logic [31:0]     output_out,
    output logic            output_out_stb,
    input  logic            output_out_ack,
    output logic [N-1:0]    grant,
    output logic            exception
);

    localparam int c_gw = (N > 1) ? $clog2(N) : 1;
    localparam int c_bw = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int c_sw = $clog2(TIMEOUT + 1);

    localparam logic [c_gw-1:0] c_last_port  = c_gw'(N - 1);
    localparam logic [c_bw-1:0] c_burst_last = c_bw'(MAX_BURST - 1);
    localparam logic [c_sw-1:0] c_stall_max  = c_sw'(TIMEOUT);
    localparam logic [c_sw-1:0] c_stall_trip = c_sw'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_gw-1:0]   r_g, w_g_nxt;
    logic [c_gw-1:0]   r_ptr, w_ptr_nxt;
    logic [c_bw-1:0]   r_burst, w_burst_nxt;
    logic [c_sw-1:0]   r_stall, w_stall_nxt;
    logic              r_exc, w_exc_nxt;
    logic [31:0]       r_out, w_out_nxt;
    logic              r_out_stb, w_out_stb_nxt;
    logic [N-1:0]      r_ack, w_ack_nxt;
    logic [N-1:0]      r_grant, w_grant_nxt;

    logic [31:0]       w_words [N];
    logic [c_gw-1:0]   w_ptr_inc;
    logic [c_gw-1:0]   w_idle_g;
    logic [c_gw-1:0]   w_rot_g;
    logic              w_any;
    logic              w_stalled;

    // First requester at or after 'start' in circular order.
    function automatic logic [c_gw-1:0] next_grant(input logic [N-1:0]    req,
                                                   input logic [c_gw-1:0] start);
        logic [c_gw-1:0] sel;
        logic [c_gw-1:0] k;
        logic            found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = c_gw'((int'(start) + i) % N);
            if (!found && req[k]) begin
                sel   = k;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [c_gw-1:0] k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_words[gi] = input_in[32*gi +: 32];
    end

    assign w_any     = |input_in_stb;
    assign w_ptr_inc = (r_g == c_last_port) ? '0 : r_g + c_gw'(1);
    assign w_idle_g  = next_grant(input_in_stb, r_ptr);
    assign w_rot_g   = next_grant(input_in_stb, w_ptr_inc);
    assign w_stalled = (r_state == SEND) && !output_out_ack;

    always_comb begin
        w_state_nxt   = r_state;
        w_g_nxt       = r_g;
        w_ptr_nxt     = r_ptr;
        w_burst_nxt   = r_burst;
        w_out_nxt     = r_out;
        w_out_stb_nxt = r_out_stb;
        w_ack_nxt     = r_ack;
        w_grant_nxt   = r_grant;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_g_nxt     = w_idle_g;
                    w_burst_nxt = '0;
                    w_ack_nxt   = onehot(w_idle_g);
                    w_grant_nxt = onehot(w_idle_g);
                    w_state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                w_ack_nxt = '0;
                if (input_in_stb[r_g]) begin
                    w_out_nxt     = w_words[r_g];
                    w_out_stb_nxt = 1'b1;
                    w_state_nxt   = SEND;
                end else begin
                    // Producer withdrew its request: give up the slot entirely.
                    w_ptr_nxt   = w_ptr_inc;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (output_out_ack) begin
                    w_out_stb_nxt = 1'b0;
                    if ((r_burst < c_burst_last) && input_in_stb[r_g]) begin
                        w_burst_nxt = r_burst + c_bw'(1);
                        w_ack_nxt   = onehot(r_g);
                        w_state_nxt = ACCEPT;
                    end else begin
                        w_ptr_nxt = w_ptr_inc;
                        if (w_any) begin
                            w_g_nxt     = w_rot_g;
                            w_burst_nxt = '0;
                            w_ack_nxt   = onehot(w_rot_g);
                            w_grant_nxt = onehot(w_rot_g);
                            w_state_nxt = ACCEPT;
                        end else begin
                            w_grant_nxt = '0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_out_stb_nxt = 1'b0;
                w_ack_nxt     = '0;
                w_grant_nxt   = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // Watchdog: the exception latches on the TIMEOUT-th consecutive stalled edge.
    always_comb begin
        w_stall_nxt = '0;
        w_exc_nxt   = r_exc;
        if (w_stalled) begin
            w_stall_nxt = (r_stall == c_stall_max) ? r_stall : r_stall + c_sw'(1);
            if (r_stall == c_stall_trip) begin
                w_exc_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_g       <= '0;
            r_ptr     <= '0;
            r_burst   <= '0;
            r_stall   <= '0;
            r_exc     <= 1'b0;
            r_out     <= '0;
            r_out_stb <= 1'b0;
            r_ack     <= '0;
            r_grant   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_g       <= w_g_nxt;
            r_ptr     <= w_ptr_nxt;
            r_burst   <= w_burst_nxt;
            r_stall   <= w_stall_nxt;
            r_exc     <= w_exc_nxt;
            r_out     <= w_out_nxt;
            r_out_stb <= w_out_stb_nxt;
            r_ack     <= w_ack_nxt;
            r_grant   <= w_grant_nxt;
        end
    end

    assign input_in_ack   = r_ack;
    assign output_out     = r_out;
    assign output_out_stb = r_out_stb;
    assign grant          = r_grant;
    assign exception      = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arbiter
// Brief    : Self-checking bench for stream_arbiter (N=4, MAX_BURST=2, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_arbiter;

    localparam int N         = 4;
    localparam int MAX_BURST = 2;
    localparam int TIMEOUT   = 16;

    logic            clk;
    logic            rst_n;
    logic [N*32-1:0] input_in;
    logic [N-1:0]    input_in_stb;
    logic [N-1:0]    input_in_ack;
    logic [31:0]     output_out;
    logic            output_out_stb;
    logic            output_out_ack;
    logic [N-1:0]    grant;
    logic            exception;

    stream_arbiter #(
        .N        (N),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_in      (input_in),
        .input_in_stb  (input_in_stb),
        .input_in_ack  (input_in_ack),
        .output_out    (output_out),
        .output_out_stb(output_out_stb),
        .output_out_ack(output_out_ack),
        .grant         (grant),
        .exception     (exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row: which ports request and how many words each; expected output port order,
    // one nibble per word, first word in the low nibble.
    typedef struct {
        logic [N-1:0] mask;
        int           nwords;
        int           len;
        logic [63:0]  order;
    } vec_t;

    vec_t         tbl [5];
    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;
    int           n_out    = 0;
    int           last_out = -1;
    bit           proto_en = 1'b1;
    bit           gap_en   = 1'b0;
    bit           rand_en  = 1'b0;
    int           ack_mode = 0;
    logic [N-1:0] stb_r    = '0;
    int           remaining [N];
    int           seqn [N];
    logic [31:0]  exp_q [$];
    int           got [$];

    function automatic logic [31:0] mkword(input int k, input int s);
        return {8'(k), 24'(s * 17 + 17)};
    endfunction

    function automatic logic [N-1:0] port_mask(input int p);
        return (p >= 0 && p < N) ? (N'(1) << p) : '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_bench();
        input_in_stb   = '0;
        output_out_ack = 1'b0;
        stb_r          = '0;
        last_out       = -1;
        exp_q.delete();
        got.delete();
        for (int k = 0; k < N; k++) begin
            remaining[k] = 0;
            seqn[k]      = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_bench();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge: drive inputs for the coming edge, score the handshakes
    // that edge will complete, then advance to the next negedge.
    task automatic step();
        logic [31:0] e;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (!stb_r[k] && remaining[k] != 0)
                stb_r[k] = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            input_in[32*k +: 32] = mkword(k, seqn[k]);
        end
        input_in_stb = stb_r;
        case (ack_mode)
            0:       output_out_ack = 1'b1;
            1:       output_out_ack = ($urandom_range(0, 3) != 0);
            default: output_out_ack = 1'b0;
        endcase

        if (proto_en) begin
            check("ack_without_stb", 32'(input_in_ack & ~input_in_stb), 32'd0);
            check("ack_onehot", 32'($onehot0(input_in_ack)), 32'd1);
            check("grant_onehot", 32'($onehot0(grant)), 32'd1);
        end
        for (int k = 0; k < N; k++) begin
            if (input_in_stb[k] && input_in_ack[k]) begin
                exp_q.push_back(mkword(k, seqn[k]));
                seqn[k]++;
                if (remaining[k] > 0) remaining[k]--;
                stb_r[k] = 1'b0;
            end
        end
        if (output_out_stb && output_out_ack) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_output: got %h, required no word (cycle %0d)", output_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_word", output_out, e);
                check("out_grant", 32'(grant), 32'(port_mask(int'(e[31:24]))));
                got.push_back(int'(e[31:24]));
                if (gap_en && last_out >= 0) check("out_gap", 32'(cyc - last_out), 32'd2);
                last_out = cyc;
            end
        end
        @(negedge clk);
    endtask

    function automatic bit drained();
        bit d;
        d = (exp_q.size() == 0) && (stb_r == '0);
        for (int k = 0; k < N; k++) if (remaining[k] != 0) d = 1'b0;
        return d;
    endfunction

    task automatic run_until_idle(input int budget, input string name);
        int i;
        i = 0;
        while (!drained() && i < budget) begin
            step();
            i++;
        end
        if (!drained()) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending words, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_out_stb(input string name);
        int i;
        i = 0;
        while (!output_out_stb && i < 10) begin
            step();
            i++;
        end
        check(name, 32'(output_out_stb), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          base;
        int          i;

        rst_n          = 1'b0;
        input_in       = '0;
        input_in_stb   = '0;
        output_out_ack = 1'b0;

        tbl[0] = '{4'b0100, 3, 3,  64'h0000_0000_0000_0222};
        tbl[1] = '{4'b1111, 4, 16, 64'h3322_1100_3322_1100};
        tbl[2] = '{4'b1010, 3, 6,  64'h0000_0000_0031_3311};
        tbl[3] = '{4'b1001, 2, 4,  64'h0000_0000_0000_3300};
        tbl[4] = '{4'b0110, 1, 2,  64'h0000_0000_0000_0021};

        do_reset();
        check("rst_ack", 32'(input_in_ack), 32'd0);
        check("rst_out", output_out, 32'd0);
        check("rst_out_stb", 32'(output_out_stb), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_exception", 32'(exception), 32'd0);

        // Arbitration order and throughput from a fresh reset.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            ack_mode = 0;
            rand_en  = 1'b0;
            gap_en   = 1'b1;
            for (int k = 0; k < N; k++) remaining[k] = tbl[r].mask[k] ? tbl[r].nwords : 0;
            run_until_idle(200, "table");
            check($sformatf("table%0d_len", r), 32'(got.size()), 32'(tbl[r].len));
            for (int j = 0; j < tbl[r].len && j < got.size(); j++)
                check($sformatf("table%0d_order", r), 32'(got[j]), 32'(tbl[r].order[4*j +: 4]));
        end
        gap_en = 1'b0;

        // Consumer backpressure: word and stb hold, no input ack, delivered once.
        do_reset();
        remaining[0] = 2;
        ack_mode     = 2;
        wait_out_stb("bp_reached_send");
        held = output_out;
        repeat (10) begin
            step();
            check("bp_word_stable", output_out, held);
            check("bp_stb_stable", 32'(output_out_stb), 32'd1);
            check("bp_no_input_ack", 32'(input_in_ack), 32'd0);
        end
        ack_mode = 0;
        base     = n_out;
        run_until_idle(100, "bp");
        check("bp_word_count", 32'(n_out - base), 32'd2);

        // Watchdog: exception on the 16th stalled edge, sticky afterwards.
        do_reset();
        remaining[2] = 2;
        ack_mode     = 0;
        run_until_idle(100, "wd_pre");
        remaining[2] = 1;
        ack_mode     = 2;
        wait_out_stb("wd_reached_send");
        repeat (15) @(negedge clk);
        check("exc_before_timeout", 32'(exception), 32'd0);
        @(negedge clk);
        check("exc_at_timeout", 32'(exception), 32'd1);
        ack_mode     = 0;
        remaining[0] = 2;
        base         = n_out;
        run_until_idle(100, "wd_resume");
        check("exc_sticky", 32'(exception), 32'd1);
        check("wd_words_after", 32'(n_out - base), 32'd3);

        // Asynchronous reset between edges while a word is held in SEND.
        remaining[2] = 1;
        ack_mode     = 2;
        wait_out_stb("ar_reached_send");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out", output_out, 32'd0);
        check("ar_out_stb", 32'(output_out_stb), 32'd0);
        check("ar_ack", 32'(input_in_ack), 32'd0);
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_exception", 32'(exception), 32'd0);
        clear_bench();
        @(negedge clk);
        rst_n = 1'b1;
        remaining[0] = 1;
        remaining[3] = 1;
        ack_mode     = 0;
        run_until_idle(100, "ar_post");
        check("ar_post_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("ar_first_port", 32'(got[0]), 32'd0);
            check("ar_second_port", 32'(got[1]), 32'd3);
        end

        // Requester 1 withdraws during ACCEPT; pointer must move past it.
        do_reset();
        @(negedge clk);
        input_in[32*1 +: 32] = mkword(1, 0);
        input_in_stb         = 4'b0010;
        @(negedge clk);
        check("wd_accept_ack", 32'(input_in_ack), 32'h2);
        input_in[32*2 +: 32] = mkword(2, 0);
        input_in_stb         = 4'b0100;
        @(negedge clk);
        check("withdraw_no_ack", 32'(input_in_ack), 32'd0);
        check("withdraw_idle_grant", 32'(grant), 32'd0);
        check("withdraw_no_out", 32'(output_out_stb), 32'd0);
        input_in_stb = 4'b0110;
        @(negedge clk);
        check("withdraw_regrant", 32'(grant), 32'h4);
        check("withdraw_reack", 32'(input_in_ack), 32'h4);
        stb_r        = 4'b0110;
        remaining[1] = 1;
        remaining[2] = 1;
        ack_mode     = 0;
        run_until_idle(100, "withdraw");
        check("withdraw_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("withdraw_first", 32'(got[0]), 32'd2);
            check("withdraw_second", 32'(got[1]), 32'd1);
        end

        // Random requests and consumer stalls, 10k words through the scoreboard.
        do_reset();
        rand_en  = 1'b1;
        ack_mode = 1;
        for (int k = 0; k < N; k++) remaining[k] = -1;
        base = n_out;
        i    = 0;
        while ((n_out - base) < 10000 && i < 60000) begin
            step();
            i++;
        end
        check("random_word_count", 32'((n_out - base) >= 10000), 32'd1);
        for (int k = 0; k < N; k++) remaining[k] = 0;
        ack_mode = 0;
        run_until_idle(200, "random_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, %0d errors so far", n_err);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
